// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker: exhaustive truth-table sweeper for N-input De Morgan
// logic. Walks vec through 0..2^N_IN-1, lets the external DUT settle, then
// checks dut_inv against ~vec and dut_and_inv against ~|vec. It reports the
// pass/fail result, the mismatch count and the first failing vector.
module demorgan_sweep_checker #(
  parameter int N_IN         = 2,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic [N_IN-1:0] dut_inv,
  input  logic            dut_and_inv,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]      CNT_ONE     = 4'd1;
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       mismatch;
  logic       last_vec;

  // Golden compare against the De Morgan identities, and detection of the final vector
  always_comb begin
    mismatch = (dut_inv != ~vec) || (dut_and_inv != ~|vec);
    last_vec = &vec;
  end

  // Sweep sequencer: every output is registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state      <= S_APPLY;
            settle_cnt <= '0;
            vec        <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
          end
        end
        S_APPLY: begin
          if (abort) begin
            state <= S_IDLE;
            vec   <= '0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + CNT_ONE;
          end
        end
        S_CHECK: begin
          // abort takes priority, so the vector under check is not scored
          if (abort) begin
            state <= S_IDLE;
            vec   <= '0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            if (mismatch) begin
              err_count <= err_count + ERR_ONE;
              if (!fail_valid) begin
                fail_vec   <= vec;
                fail_valid <= 1'b1;
              end
            end
            if (last_vec || (mismatch && (STOP_ON_FAIL != 0))) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
            end else begin
              state      <= S_APPLY;
              settle_cnt <= '0;
              vec        <= vec + VEC_ONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          vec   <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          vec   <= '0;
        end
      endcase
    end
  end

endmodule
